// File: rtl/eth_mac_pkg.sv
// Shared Ethernet MAC definitions: transmit FSM states and frame constants.
package eth_mac_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_ABORT,
        ST_DRAIN,
        ST_IFG
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam logic [31:0] CRC_POLY_REFL   = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;
    localparam int          MIN_FRAME_BYTES = 60;

endpackage

// File: rtl/mac_crc32_d8.sv
// Combinational IEEE 802.3 CRC32 update by one byte (reflected form), shared by TX and RX.
module mac_crc32_d8
    import eth_mac_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i ^ {24'h0, data_i};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/mac_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, optional pad, FCS and inter-frame gap.
// Define MAC_TX_PAD_EN to zero-pad short frames to the 60-byte minimum before the FCS.
module mac_tx_framer
    import eth_mac_pkg::*;
#(
    parameter int IFG_BYTES      = 12,
    parameter int PREAMBLE_BYTES = 7
) (
    input  logic        tx_clk_in,
    input  logic        tx_rstn_in,
    input  logic [7:0]  mac_tdata_in,
    input  logic        mac_tvalid_in,
    output logic        mac_tready_out,
    input  logic        mac_tlast_in,
    output logic [7:0]  gmii_txd_out,
    output logic        gmii_tx_en_out,
    output logic        gmii_tx_er_out,
    output logic        tx_busy_out,
    output logic [15:0] frame_cnt_out,
    output logic [15:0] underrun_cnt_out
);

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_BYTES - 1);
    localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);
`ifdef MAC_TX_PAD_EN
    localparam logic [10:0] MIN_BYTES = 11'(MIN_FRAME_BYTES);
`endif

    tx_state_t   state_q;
    logic [7:0]  cnt_q;
    logic [10:0] byte_cnt_q;
    logic [10:0] byte_cnt_inc;
    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [7:0]  crc_byte;
    logic [7:0]  txd_q;
    logic        tx_en_q;
    logic        tx_er_q;
    logic [15:0] frame_cnt_q;
    logic [15:0] underrun_cnt_q;

    assign mac_tready_out = (state_q == ST_SFD) || (state_q == ST_DATA) || (state_q == ST_DRAIN);
    assign byte_cnt_inc   = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
    // Pad bytes are zeros but still count toward the FCS.
    assign crc_byte       = (state_q == ST_PAD) ? 8'h00 : mac_tdata_in;

    mac_crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (crc_byte),
        .crc_o  (crc_d)
    );

    always_ff @(posedge tx_clk_in or negedge tx_rstn_in) begin
        if (!tx_rstn_in) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            byte_cnt_q     <= '0;
            crc_q          <= CRC_INIT;
            txd_q          <= '0;
            tx_en_q        <= 1'b0;
            tx_er_q        <= 1'b0;
            frame_cnt_q    <= '0;
            underrun_cnt_q <= '0;
        end else begin
            // Outputs are registered for the state being entered, so each state shows its own byte.
            txd_q   <= 8'h00;
            tx_en_q <= 1'b0;
            tx_er_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mac_tvalid_in) begin
                        state_q    <= ST_PREAMBLE;
                        txd_q      <= PREAMBLE_BYTE;
                        tx_en_q    <= 1'b1;
                        cnt_q      <= '0;
                        byte_cnt_q <= '0;
                        crc_q      <= CRC_INIT;
                    end
                end
                ST_PREAMBLE: begin
                    tx_en_q <= 1'b1;
                    if (cnt_q == PRE_LAST) begin
                        txd_q   <= SFD_BYTE;
                        state_q <= ST_SFD;
                        cnt_q   <= '0;
                    end else begin
                        txd_q <= PREAMBLE_BYTE;
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_SFD, ST_DATA: begin
                    tx_en_q <= 1'b1;
                    if (!mac_tvalid_in) begin
                        state_q <= ST_ABORT;
                        tx_er_q <= 1'b1;
                    end else begin
                        txd_q      <= mac_tdata_in;
                        crc_q      <= crc_d;
                        byte_cnt_q <= byte_cnt_inc;
                        state_q    <= ST_DATA;
                        if (mac_tlast_in) begin
                            cnt_q <= '0;
`ifdef MAC_TX_PAD_EN
                            state_q <= (byte_cnt_inc < MIN_BYTES) ? ST_PAD : ST_FCS;
`else
                            state_q <= ST_FCS;
`endif
                        end
                    end
                end
`ifdef MAC_TX_PAD_EN
                ST_PAD: begin
                    tx_en_q    <= 1'b1;
                    crc_q      <= crc_d;
                    byte_cnt_q <= byte_cnt_inc;
                    if (byte_cnt_inc >= MIN_BYTES) state_q <= ST_FCS;
                end
`endif
                ST_FCS: begin
                    tx_en_q <= 1'b1;
                    txd_q   <= ~crc_q[{cnt_q[1:0], 3'b000} +: 8];
                    if (cnt_q == 8'd3) begin
                        state_q     <= ST_IFG;
                        cnt_q       <= '0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_ABORT: begin
                    // Underrun can only occur before tlast is accepted, so the rest must be drained.
                    underrun_cnt_q <= underrun_cnt_q + 16'd1;
                    state_q        <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (mac_tvalid_in && mac_tlast_in) begin
                        state_q <= ST_IFG;
                        cnt_q   <= '0;
                    end
                end
                ST_IFG: begin
                    if (cnt_q == IFG_LAST) state_q <= ST_IDLE;
                    else                   cnt_q   <= cnt_q + 8'd1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gmii_txd_out     = txd_q;
    assign gmii_tx_en_out   = tx_en_q;
    assign gmii_tx_er_out   = tx_er_q;
    assign tx_busy_out      = (state_q != ST_IDLE);
    assign frame_cnt_out    = frame_cnt_q;
    assign underrun_cnt_out = underrun_cnt_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Self-checking bench for mac_tx_framer: known-CRC vector table, random frames against a
// queue-based frame model, back-to-back gap, underrun abort, async reset and counter wrap.
`timescale 1ns/1ps
module tb_mac_tx_framer;

    localparam int IFG = 12;
    localparam int PRE = 7;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic [7:0]  tdata  = 8'h00;
    logic        tvalid = 1'b0;
    logic        tlast  = 1'b0;
    logic        tready;
    logic [7:0]  txd;
    logic        en;
    logic        er;
    logic        busy;
    logic [15:0] fcnt;
    logic [15:0] ucnt;

    always #4 clk = ~clk;

    mac_tx_framer #(.IFG_BYTES(IFG), .PREAMBLE_BYTES(PRE)) dut (
        .tx_clk_in        (clk),
        .tx_rstn_in       (rst_n),
        .mac_tdata_in     (tdata),
        .mac_tvalid_in    (tvalid),
        .mac_tready_out   (tready),
        .mac_tlast_in     (tlast),
        .gmii_txd_out     (txd),
        .gmii_tx_en_out   (en),
        .gmii_tx_er_out   (er),
        .tx_busy_out      (busy),
        .frame_cnt_out    (fcnt),
        .underrun_cnt_out (ucnt)
    );

    typedef logic [7:0] bq_t[$];
    typedef struct packed {logic en; logic er; logic [7:0] d;} smp_t;
    typedef struct {string txt; logic [31:0] crc;} vec_t;

    smp_t        log_q[$];
    bq_t         exp_q;
    bq_t         run_q;
    logic [31:0] crc_tbl [256];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_frames = 0;

    always @(negedge clk) log_q.push_back({en, er, txd});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] crc_of(input bq_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) c = crc_tbl[c[7:0] ^ b[i]] ^ (c >> 8);
        return ~c;
    endfunction

    function automatic int body_len(input int n);
`ifdef MAC_TX_PAD_EN
        return (n < 60) ? 60 : n;
`else
        return n;
`endif
    endfunction

    // Expected GMII byte stream of one complete frame.
    task automatic model_frame(input bq_t p);
        bq_t         body;
        logic [31:0] f;
        body = p;
        while (body.size() < body_len(p.size())) body.push_back(8'h00);
        f = crc_of(body);
        exp_q.delete();
        repeat (PRE) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (body[i]) exp_q.push_back(body[i]);
        for (int k = 0; k < 4; k++) exp_q.push_back(f[8*k +: 8]);
    endtask

    task automatic get_run(input int from, output int s, output int e);
        int i;
        i = from;
        s = -1;
        run_q.delete();
        while (i < log_q.size() && !log_q[i].en) i++;
        if (i < log_q.size()) s = i;
        while (i < log_q.size() && log_q[i].en) begin
            run_q.push_back(log_q[i].d);
            i++;
        end
        e = i;
    endtask

    task automatic cmp_stream(input string name);
        int n;
        int bad;
        n   = (run_q.size() < exp_q.size()) ? run_q.size() : exp_q.size();
        bad = (run_q.size() == exp_q.size()) ? -1 : n;
        for (int i = n - 1; i >= 0; i--) if (run_q[i] !== exp_q[i]) bad = i;
        n_cmp++;
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL %s: stream differs at byte %0d, got %0d bytes, expected %0d bytes",
                     name, bad, run_q.size(), exp_q.size());
        end
    endtask

    task automatic wait_idle(input string name);
        int g;
        g = 0;
        @(negedge clk);
        while ((busy || en) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: idle not reached, got busy=%0b, expected 0", name, busy);
        end
    endtask

    task automatic drive(input bq_t p, input int gap_at, input bit hold, input bit clr);
        int i;
        int g;
        bit hs;
        i = 0;
        g = 0;
        if (clr) begin
            @(posedge clk); #1;
            log_q.delete();
        end
        tdata  = p[0];
        tlast  = (p.size() == 1);
        tvalid = 1'b1;
        while (i < p.size() && g < 5000) begin
            @(negedge clk);
            hs = tready && tvalid;
            @(posedge clk); #1;
            g++;
            if (hs) begin
                i++;
                if (i < p.size()) begin
                    tdata = p[i];
                    tlast = (i == p.size() - 1);
                end
                if (i == gap_at) begin
                    tvalid = 1'b0;
                    @(posedge clk); #1;
                    tvalid = 1'b1;
                end
            end
        end
        if (g >= 5000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drive: accepted %0d bytes, expected %0d", i, p.size());
        end
        if (!hold) begin
            tvalid = 1'b0;
            tlast  = 1'b0;
        end
    endtask

    task automatic run_frame(input string name, input bq_t p);
        int s;
        int e;
        drive(p, -1, 1'b0, 1'b1);
        wait_idle(name);
        model_frame(p);
        get_run(0, s, e);
        cmp_stream({name, "_stream"});
        exp_frames = (exp_frames + 1) & 16'hFFFF;
        check({name, "_frame_cnt"}, fcnt, exp_frames);
    endtask

    vec_t        tbl [5];
    bq_t         p;
    bq_t         p2;
    int          s, e, s2, e2, ner, er_idx, pad_wait;
    logic [31:0] fcs_got, fcs_req;

    initial begin
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tbl[n] = c;
        end
        tbl[0].txt = "123456789";     tbl[0].crc = 32'hCBF43926;
        tbl[1].txt = "a";             tbl[1].crc = 32'hE8B7BE43;
        tbl[2].txt = "abc";           tbl[2].crc = 32'h352441C2;
        tbl[3].txt = "message digest"; tbl[3].crc = 32'h20159D7F;
        tbl[4].txt = "The quick brown fox jumps over the lazy dog"; tbl[4].crc = 32'h414FA339;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_en", en, 0);
        check("rst_tx_er", er, 0);
        check("rst_txd", txd, 0);
        check("rst_tready", tready, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", fcnt, 0);
        check("rst_underrun_cnt", ucnt, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Known-CRC vector table
        for (int r = 0; r < 5; r++) begin
            p.delete();
            for (int i = 0; i < tbl[r].txt.len(); i++) p.push_back(tbl[r].txt[i]);
            drive(p, -1, 1'b0, 1'b1);
            wait_idle("table");
            model_frame(p);
            get_run(0, s, e);
            cmp_stream($sformatf("table%0d_stream", r));
            check($sformatf("table%0d_tx_en_cycles", r), run_q.size(), PRE + 1 + body_len(p.size()) + 4);
            fcs_got = (run_q.size() >= 4) ? {run_q[run_q.size()-1], run_q[run_q.size()-2],
                                             run_q[run_q.size()-3], run_q[run_q.size()-4]} : 32'h0;
`ifdef MAC_TX_PAD_EN
            fcs_req = {exp_q[exp_q.size()-1], exp_q[exp_q.size()-2], exp_q[exp_q.size()-3], exp_q[exp_q.size()-4]};
`else
            fcs_req = tbl[r].crc;
`endif
            check($sformatf("table%0d_fcs", r), fcs_got, fcs_req);
            if (r == 0) check("latency_first_preamble", s, 1);
            exp_frames++;
            check($sformatf("table%0d_frame_cnt", r), fcnt, exp_frames);
        end

        // Random frames
        for (int r = 0; r < 8; r++) begin
            p.delete();
            repeat ($urandom_range(1, 100)) p.push_back(8'($urandom));
            run_frame($sformatf("rand%0d", r), p);
        end

        // Back-to-back: second frame held valid through the gap
        p.delete();
        p2.delete();
        for (int i = 0; i < 72; i++) p.push_back(8'($urandom));
        for (int i = 0; i < 30; i++) p2.push_back(8'($urandom));
        drive(p, -1, 1'b1, 1'b1);
        drive(p2, -1, 1'b0, 1'b0);
        wait_idle("b2b");
        get_run(0, s, e);
        model_frame(p);
        cmp_stream("b2b_frame1");
        get_run(e, s2, e2);
        model_frame(p2);
        cmp_stream("b2b_frame2");
        check("b2b_ifg_cycles", s2 - e, IFG);
        exp_frames += 2;
        check("b2b_frame_cnt", fcnt, exp_frames);

        // Underrun after 20 payload bytes
        p.delete();
        for (int i = 0; i < 30; i++) p.push_back(8'($urandom));
        drive(p, 20, 1'b0, 1'b1);
        wait_idle("underrun");
        get_run(0, s, e);
        exp_q.delete();
        repeat (PRE) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 20; i++) exp_q.push_back(p[i]);
        exp_q.push_back(8'h00);
        cmp_stream("underrun_stream");
        ner = 0;
        er_idx = -1;
        foreach (log_q[i]) if (log_q[i].er) begin ner++; er_idx = i; end
        check("underrun_er_cycles", ner, 1);
        check("underrun_er_position", er_idx - s, PRE + 1 + 20);
        get_run(e, s2, e2);
        check("underrun_no_tx_en_in_drain", s2, -1);
        check("underrun_cnt", ucnt, 1);
        check("underrun_frame_cnt", fcnt, exp_frames);

        // Asynchronous reset during FCS byte 2
        p.delete();
        for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));
        drive(p, -1, 1'b0, 1'b1);
        model_frame(p);
        pad_wait = body_len(p.size()) - p.size();
        repeat (3 + pad_wait) @(posedge clk);
        #1;
        check("fcs2_before_reset", txd, exp_q[exp_q.size()-2]);
        check("fcs2_tx_en", en, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_tx_en", en, 0);
        check("async_rst_txd", txd, 0);
        check("async_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_frame_cnt", fcnt, 0);
        check("post_rst_underrun_cnt", ucnt, 0);
        exp_frames = 0;
        run_frame("post_rst", p);

        // Frame counter wrap
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        #1 release dut.frame_cnt_q;
        check("wrap_preload", fcnt, 16'hFFFF);
        exp_frames = 16'hFFFF;
        p.delete();
        for (int i = 0; i < 60; i++) p.push_back(8'($urandom));
        run_frame("wrap", p);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
